// File: rtl/fft_reorder_pkg.sv
// fft_reorder_pkg: shared constants, sample type, reader state encoding and the
// bit-reversal helper used by the FFT output reorder stage.
//
// Ports: none (package).
// Optional build macro used by the stage: FFT_REORDER_BYPASS_EN.

package fft_reorder_pkg;

   localparam int unsigned WIDTH      = 13;
   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned N_POINT    = 512;
   localparam int unsigned BEATS      = N_POINT / DATA_WIDTH;
   localparam int unsigned LOG2N      = $clog2(N_POINT);
   localparam int unsigned LANE_W     = $clog2(DATA_WIDTH);
   localparam int unsigned BEAT_W     = $clog2(BEATS);

   typedef logic signed [WIDTH-1:0] sample_t;

   typedef enum logic [0:0] {
      StIdle,
      StRead
   } rd_state_e;

   // Mirror the LOG2N-bit index: bit i moves to bit LOG2N-1-i.
   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = idx[LOG2N-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: one ping-pong bank holding a full frame of complex samples.
//
// Ports:
//   clk            system clock (storage has no reset)
//   wr_en          write the current beat
//   wr_beat        beat index of the incoming beat (position = beat*DATA_WIDTH + lane)
//   wr_re, wr_im   DATA_WIDTH lanes of incoming samples
//   rd_beat        output beat index t (bin = t*DATA_WIDTH + lane)
//   bypass         1: read position = bin; 0: read position = bitrev(bin)
//   rd_re, rd_im   DATA_WIDTH combinational read lanes

module fft_reorder_bank
   import fft_reorder_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [BEAT_W-1:0] wr_beat,
   input  sample_t           wr_re [DATA_WIDTH],
   input  sample_t           wr_im [DATA_WIDTH],
   input  logic [BEAT_W-1:0] rd_beat,
   input  logic              bypass,
   output sample_t           rd_re [DATA_WIDTH],
   output sample_t           rd_im [DATA_WIDTH]
);

   sample_t mem_re [N_POINT];
   sample_t mem_im [N_POINT];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int l = 0; l < DATA_WIDTH; l++) begin
            mem_re[{wr_beat, LANE_W'(l)}] <= wr_re[l];
            mem_im[{wr_beat, LANE_W'(l)}] <= wr_im[l];
         end
      end
   end

   logic [LOG2N-1:0] bin;
   logic [LOG2N-1:0] pos;

   always_comb begin
      bin = '0;
      pos = '0;
      for (int l = 0; l < DATA_WIDTH; l++) begin
         bin      = {rd_beat, LANE_W'(l)};
         pos      = bypass ? bin : bitrev(bin);
         rd_re[l] = mem_re[pos];
         rd_im[l] = mem_im[pos];
      end
   end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: takes 512-point frames arriving as 32 bit-reversed beats of
// 16 complex lanes, stores each frame in one of two ping-pong banks and replays it
// in natural bin order at one beat per cycle, allowing back-to-back frames.
//
// Ports:
//   clk             system clock
//   rstn            asynchronous active-low reset
//   reorder_bypass  (only with FFT_REORDER_BYPASS_EN) replay in input order
//   din_valid       input beat qualifier
//   din_re, din_im  input lanes, bit-reversed order
//   dout_valid      output beat qualifier
//   dout_re/dout_im output lanes, natural order (hold when dout_valid is low)
//   dout_sof        high with beat 0 of each output frame
//   overflow        sticky: an input beat was dropped
//
// Build macro: FFT_REORDER_BYPASS_EN adds the reorder_bypass input.

module fft_bitrev_reorder #(
   parameter int unsigned WIDTH      = fft_reorder_pkg::WIDTH,
   parameter int unsigned DATA_WIDTH = fft_reorder_pkg::DATA_WIDTH,
   parameter int unsigned N_POINT    = fft_reorder_pkg::N_POINT
) (
   input  logic                    clk,
   input  logic                    rstn,
`ifdef FFT_REORDER_BYPASS_EN
   input  logic                    reorder_bypass,
`endif
   input  logic                    din_valid,
   input  logic signed [WIDTH-1:0] din_re [0:DATA_WIDTH-1],
   input  logic signed [WIDTH-1:0] din_im [0:DATA_WIDTH-1],
   output logic                    dout_valid,
   output logic signed [WIDTH-1:0] dout_re [0:DATA_WIDTH-1],
   output logic signed [WIDTH-1:0] dout_im [0:DATA_WIDTH-1],
   output logic                    dout_sof,
   output logic                    overflow
);

   import fft_reorder_pkg::*;

   logic bypass;
`ifdef FFT_REORDER_BYPASS_EN
   assign bypass = reorder_bypass;
`else
   assign bypass = 1'b0;
`endif

   rd_state_e         state_q, state_d;
   logic              rd_active;
   logic [1:0]        full_q, full_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [BEAT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [BEAT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic              overflow_d;
   logic              wr_accept, wr_last, rd_last;
   logic [1:0]        bank_wr_en;
   sample_t           bank_re [2][DATA_WIDTH];
   sample_t           bank_im [2][DATA_WIDTH];

   assign rd_active = (state_q == StRead);

   always_comb begin
      wr_accept  = din_valid && !full_q[wr_bank_q];
      wr_last    = wr_accept && (wr_cnt_q == BEAT_W'(BEATS - 1));
      rd_last    = rd_active && (rd_cnt_q == BEAT_W'(BEATS - 1));
      wr_cnt_d   = wr_accept ? wr_cnt_q + 1'b1 : wr_cnt_q;
      wr_bank_d  = wr_last ? ~wr_bank_q : wr_bank_q;
      rd_cnt_d   = rd_active ? rd_cnt_q + 1'b1 : rd_cnt_q;
      rd_bank_d  = rd_last ? ~rd_bank_q : rd_bank_q;
      overflow_d = overflow || (din_valid && full_q[wr_bank_q]);

      // Writer and reader never touch the same bank's flag in one cycle.
      full_d = full_q;
      if (wr_last) full_d[wr_bank_q] = 1'b1;
      if (rd_last) full_d[rd_bank_q] = 1'b0;

      bank_wr_en            = '0;
      bank_wr_en[wr_bank_q] = wr_accept;

      // Looking at full_d lets a frame completing this cycle start the read
      // next cycle, and lets the next frame follow the last beat without a gap.
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (full_d[rd_bank_q]) state_d = StRead;
         StRead:  if (rd_last && !full_d[rd_bank_d]) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StIdle;
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         overflow  <= 1'b0;
      end else begin
         state_q   <= state_d;
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         overflow  <= overflow_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_reorder_bank u_bank (
         .clk     (clk),
         .wr_en   (bank_wr_en[b]),
         .wr_beat (wr_cnt_q),
         .wr_re   (din_re),
         .wr_im   (din_im),
         .rd_beat (rd_cnt_q),
         .bypass  (bypass),
         .rd_re   (bank_re[b]),
         .rd_im   (bank_im[b])
      );
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dout_valid <= 1'b0;
         dout_sof   <= 1'b0;
         for (int l = 0; l < DATA_WIDTH; l++) begin
            dout_re[l] <= '0;
            dout_im[l] <= '0;
         end
      end else begin
         dout_valid <= rd_active;
         dout_sof   <= rd_active && (rd_cnt_q == '0);
         if (rd_active) begin
            for (int l = 0; l < DATA_WIDTH; l++) begin
               dout_re[l] <= bank_re[rd_bank_q][l];
               dout_im[l] <= bank_im[rd_bank_q][l];
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: scoreboard bench for fft_bitrev_reorder. Expected output
// beats are pushed when the last input beat of a frame is driven and checked by a
// negedge monitor whenever dout_valid is high.

`timescale 1ns/1ps

module tb_fft_bitrev_reorder;

   localparam int W  = 13;
   localparam int DW = 16;
   localparam int NB = 32;

   logic                clk = 1'b0;
   logic                rstn;
   logic                din_valid;
   logic signed [W-1:0] din_re [0:DW-1];
   logic signed [W-1:0] din_im [0:DW-1];
   logic                dout_valid;
   logic signed [W-1:0] dout_re [0:DW-1];
   logic signed [W-1:0] dout_im [0:DW-1];
   logic                dout_sof;
   logic                overflow;
`ifdef FFT_REORDER_BYPASS_EN
   logic                reorder_bypass;
`endif

   always #5 clk = ~clk;

   fft_bitrev_reorder dut (
      .clk            (clk),
      .rstn           (rstn),
`ifdef FFT_REORDER_BYPASS_EN
      .reorder_bypass (reorder_bypass),
`endif
      .din_valid      (din_valid),
      .din_re         (din_re),
      .din_im         (din_im),
      .dout_valid     (dout_valid),
      .dout_re        (dout_re),
      .dout_im        (dout_im),
      .dout_sof       (dout_sof),
      .overflow       (overflow)
   );

   typedef struct packed {
      logic                 sof;
      logic [DW-1:0][W-1:0] re;
      logic [DW-1:0][W-1:0] im;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   beat31_cyc = 0;
   int   rise_cyc = 0;
   int   run_len = 0;
   bit   prev_valid = 1'b0;
   bit   bypass_mode = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int tb_bitrev(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 9; i++) begin
         if (((n >> i) & 1) != 0) r = r | (1 << (8 - i));
      end
      return r;
   endfunction

   task automatic push_frame(input int k);
      exp_t e;
      int   n, pos, v;
      for (int t = 0; t < NB; t++) begin
         e.sof = (t == 0);
         for (int l = 0; l < DW; l++) begin
            n       = t * DW + l;
            pos     = bypass_mode ? n : tb_bitrev(n);
            v       = pos + 512 * k;
            e.re[l] = W'(v);
            e.im[l] = W'(-v);
         end
         sb.push_back(e);
      end
   endtask

   // Input value at stored position p of frame k is p + 512*k (im negated).
   task automatic send_frame(input int k, input bit gapped, input bit push, input int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         @(posedge clk); #1;
         din_valid = 1'b1;
         for (int l = 0; l < DW; l++) begin
            din_re[l] = W'(b * DW + l + 512 * k);
            din_im[l] = W'(-(b * DW + l + 512 * k));
         end
         if (b == NB - 1) begin
            beat31_cyc = cyc;
            if (push) push_frame(k);
         end
         if (gapped) begin
            @(posedge clk); #1;
            din_valid = 1'b0;
         end
      end
   endtask

   task automatic idle_input();
      @(posedge clk); #1;
      din_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || dout_valid) && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d beats still pending, required 0", sb.size());
         sb.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      din_valid = 1'b0;
      rstn      = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   bad, li;
      if (dout_valid === 1'b1) begin
         if (!prev_valid) begin
            rise_cyc = cyc;
            run_len  = 0;
         end
         run_len++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: dout_valid=1 at cycle %0d, required no output", cyc);
         end else begin
            e   = sb.pop_front();
            bad = -1;
            for (int l = DW - 1; l >= 0; l--) begin
               if (dout_re[l] !== e.re[l] || dout_im[l] !== e.im[l]) bad = l;
            end
            if (bad >= 0 || dout_sof !== e.sof) begin
               errors++;
               li = (bad < 0) ? 0 : bad;
               $display("FAIL beat_data: lane %0d got re=%0d im=%0d sof=%b, required re=%0d im=%0d sof=%b",
                        li, dout_re[li], dout_im[li], dout_sof,
                        $signed(e.re[li]), $signed(e.im[li]), e.sof);
            end
         end
      end
      prev_valid = (dout_valid === 1'b1);
   end

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (dout_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b, required 0", dout_valid);
      end
      checks++;
      if (dout_sof !== 1'b0) begin
         errors++; $display("FAIL reset_sof: got %b, required 0", dout_sof);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL reset_overflow: got %b, required 0", overflow);
      end
      checks++;
      if (dout_re[0] !== '0 || dout_im[DW-1] !== '0) begin
         errors++;
         $display("FAIL reset_data: got re0=%0d im15=%0d, required 0 0", dout_re[0], dout_im[DW-1]);
      end
      @(posedge clk); #1 rstn = 1'b1;
   endtask

   task automatic test_ramp();
      send_frame(0, 1'b0, 1'b1, NB);
      idle_input();
      wait_drain();
      checks++;
      if (rise_cyc - beat31_cyc != 2) begin
         errors++; $display("FAIL ramp_latency: got %0d cycles, required 2", rise_cyc - beat31_cyc);
      end
      checks++;
      if (run_len != NB) begin
         errors++; $display("FAIL ramp_length: got %0d beats, required %0d", run_len, NB);
      end
   endtask

   task automatic test_gapped();
      send_frame(0, 1'b1, 1'b1, NB);
      idle_input();
      wait_drain();
      checks++;
      if (rise_cyc - beat31_cyc != 2) begin
         errors++; $display("FAIL gapped_latency: got %0d cycles, required 2", rise_cyc - beat31_cyc);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++) send_frame(k, 1'b0, 1'b1, NB);
      idle_input();
      wait_drain();
      checks++;
      if (run_len != 3 * NB) begin
         errors++; $display("FAIL b2b_contiguous: got run of %0d beats, required %0d", run_len, 3 * NB);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL b2b_overflow: got %b, required 0", overflow);
      end
   endtask

   task automatic test_overflow();
      force dut.rd_active = 1'b0;
      send_frame(0, 1'b0, 1'b1, NB);
      send_frame(1, 1'b0, 1'b1, NB);
      send_frame(2, 1'b0, 1'b0, NB);
      idle_input();
      repeat (5) @(negedge clk);
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL overflow_set: got %b, required 1", overflow);
      end
      checks++;
      if (dout_valid !== 1'b0) begin
         errors++; $display("FAIL overflow_stalled: dout_valid got %b, required 0", dout_valid);
      end
      @(posedge clk); #1;
      release dut.rd_active;
      wait_drain();
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL overflow_sticky: got %b, required 1", overflow);
      end
      checks++;
      if (run_len != 2 * NB) begin
         errors++; $display("FAIL overflow_replay: got %0d beats, required %0d", run_len, 2 * NB);
      end
   endtask

   task automatic test_reset_mid();
      reset_dut();
      @(negedge clk);
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL reset_clears_overflow: got %b, required 0", overflow);
      end
      send_frame(1, 1'b0, 1'b0, 10);
      @(posedge clk); #1;
      din_valid = 1'b0;
      rstn      = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      send_frame(2, 1'b0, 1'b1, NB);
      idle_input();
      wait_drain();
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL reset_mid_overflow: got %b, required 0", overflow);
      end
      checks++;
      if (run_len != NB) begin
         errors++; $display("FAIL reset_mid_length: got %0d beats, required %0d", run_len, NB);
      end
   endtask

`ifdef FFT_REORDER_BYPASS_EN
   task automatic test_bypass();
      @(posedge clk); #1;
      reorder_bypass = 1'b1;
      bypass_mode    = 1'b1;
      send_frame(0, 1'b0, 1'b1, NB);
      idle_input();
      wait_drain();
      checks++;
      if (rise_cyc - beat31_cyc != 2) begin
         errors++; $display("FAIL bypass_latency: got %0d cycles, required 2", rise_cyc - beat31_cyc);
      end
      reorder_bypass = 1'b0;
      bypass_mode    = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      rstn      = 1'b1;
      din_valid = 1'b0;
      for (int l = 0; l < DW; l++) begin
         din_re[l] = '0;
         din_im[l] = '0;
      end
`ifdef FFT_REORDER_BYPASS_EN
      reorder_bypass = 1'b0;
`endif
      #1 rstn = 1'b0;
      test_reset();
      test_ramp();
      test_gapped();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
`ifdef FFT_REORDER_BYPASS_EN
      test_bypass();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
